// File: rtl/alu_cmd_ctrl.sv
// Command sequencer feeding a combinational 8-bit ALU: FIFO-buffered requests, registered
// operands, one-cycle result capture onto a valid/ready response port. Macro ALU_CMD_ERR_EN adds error flagging.
module alu_cmd_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [2:0]               cmd_op_i,
  input  logic [7:0]               cmd_a_i,
  input  logic [7:0]               cmd_b_i,
  output logic [2:0]               alu_ctrl_o,
  output logic [7:0]               alu_data0_o,
  output logic [7:0]               alu_data1_o,
  input  logic [7:0]               alu_result_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [7:0]               rsp_data_o,
  output logic                     rsp_err_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  cmd_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_d;
  logic           push_c, pop_c, cap_c, done_c, empty_c;
  logic [7:0]     cap_data_c;
  cmd_t           head_c;

  assign push_c  = cmd_valid_i & cmd_ready_o;
  assign empty_c = (count_o == '0);
  assign head_c  = mem[rd_ptr_q];

  // Occupancy update; ready is registered from the next count so a full FIFO never pushes through.
  always_comb begin
    count_d = count_o;
    case ({push_c, pop_c})
      2'b10:   count_d = count_o + CW'(1);
      2'b01:   count_d = count_o - CW'(1);
      default: count_d = count_o;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_o     <= '0;
      cmd_ready_o <= 1'b1;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_o     <= count_d;
      cmd_ready_o <= (count_d < CW'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_c) mem[wr_ptr_q] <= '{op: cmd_op_i, a: cmd_a_i, b: cmd_b_i};
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; the non-empty test uses the pre-edge count, so a same-edge push is not seen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty_c) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_valid_o && rsp_ready_i) state_d = empty_c ? IDLE : EXEC;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes
  always_comb begin
    pop_c  = 1'b0;
    cap_c  = 1'b0;
    done_c = 1'b0;
    case (state_q)
      IDLE: pop_c = !empty_c;
      EXEC: cap_c = 1'b1;
      RESP: begin
        done_c = rsp_valid_o && rsp_ready_i;
        pop_c  = done_c && !empty_c;
      end
      default: ;
    endcase
  end

`ifdef ALU_CMD_ERR_EN
  logic cap_err_c;

  always_comb begin
    cap_data_c = alu_result_i;
    cap_err_c  = 1'b0;
    case (alu_ctrl_o)
      3'b011, 3'b100: begin
        if (alu_data1_o == 8'h00) begin
          cap_data_c = 8'hFF;
          cap_err_c  = 1'b1;
        end
      end
      3'b101, 3'b110, 3'b111: begin
        cap_data_c = 8'h00;
        cap_err_c  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      rsp_err_o <= 1'b0;
    else if (cap_c) rsp_err_o <= cap_err_c;
  end
`else
  assign cap_data_c = alu_result_i;
  assign rsp_err_o  = 1'b0;
`endif

  // ALU operand and response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu_ctrl_o  <= 3'b000;
      alu_data0_o <= 8'h00;
      alu_data1_o <= 8'h00;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= 8'h00;
    end else begin
      if (pop_c) begin
        alu_ctrl_o  <= head_c.op;
        alu_data0_o <= head_c.a;
        alu_data1_o <= head_c.b;
      end
      if (cap_c) begin
        rsp_valid_o <= 1'b1;
        rsp_data_o  <= cap_data_c;
      end else if (done_c) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

endmodule
